// File: rtl/mips_dmem_responder.sv
// mips_dmem_responder: responder end of the CPU data-memory interface.
// Word-organised RAM (2^ADDR_W x 32) behind a req/ack handshake, with LATENCY wait states,
// byte-lane store enables and an address-error response.
//
// Ports:
//   clk    - system clock, all state updates on the rising edge
//   reset  - synchronous, active-high reset
//   req    - request valid, sampled only while idle
//   we     - 1 = store, 0 = load
//   addr   - byte address (must be word aligned and inside the RAM)
//   wdata  - store data
//   be     - store byte enables, be[i] selects wdata[8i+7:8i]
//   ack    - one-cycle completion pulse
//   rdata  - load data, valid with ack and held afterwards
//   err    - qualifies ack: the request had an illegal address
//   busy   - high whenever a request is in flight
module mips_dmem_responder #(
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  be,
   output logic        ack,
   output logic [31:0] rdata,
   output logic        err,
   output logic        busy
);

   localparam int unsigned Depth  = 2 ** ADDR_W;
   localparam logic [3:0]  LatCnt = 4'(LATENCY);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   logic [31:0] mem [Depth];

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        be_q, be_d;
   logic              ack_q, ack_d;
   logic              err_q, err_d;
   logic [31:0]       rdata_q, rdata_d;

   logic              addr_illegal;
   logic              acc_go;
   logic              acc_we;
   logic [ADDR_W-1:0] acc_idx;
   logic [31:0]       acc_wdata;
   logic [3:0]        acc_be;
   logic [31:0]       wr_word;
   logic              mem_wr;

   // Misaligned, or any address bit above the RAM's byte range set.
   assign addr_illegal = (addr[1:0] != 2'b00) || ((addr >> (ADDR_W + 2)) != 32'd0);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      we_d      = we_q;
      idx_d     = idx_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      ack_d     = 1'b0;
      err_d     = 1'b0;
      rdata_d   = rdata_q;
      // Accesses from WAIT use the latched request.
      acc_go    = 1'b0;
      acc_we    = we_q;
      acc_idx   = idx_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;

      case (state_q)
         StIdle: begin
            if (req) begin
               we_d    = we;
               idx_d   = addr[ADDR_W+1:2];
               wdata_d = wdata;
               be_d    = be;
               if (addr_illegal) begin
                  state_d = StResp;
                  ack_d   = 1'b1;
                  err_d   = 1'b1;
                  rdata_d = '0;
               end else if (LATENCY == 0) begin
                  // Zero wait states: access straight from the live inputs on the accept edge.
                  acc_go    = 1'b1;
                  acc_we    = we;
                  acc_idx   = addr[ADDR_W+1:2];
                  acc_wdata = wdata;
                  acc_be    = be;
                  state_d   = StResp;
                  ack_d     = 1'b1;
               end else begin
                  cnt_d   = LatCnt;
                  state_d = StWait;
               end
            end
         end
         StWait: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               acc_go  = 1'b1;
               state_d = StResp;
               ack_d   = 1'b1;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (acc_go && !acc_we) begin
         rdata_d = mem[acc_idx];
      end
   end

   // Byte-lane merge of store data into the current word.
   always_comb begin
      wr_word = mem[acc_idx];
      for (int i = 0; i < 4; i++) begin
         if (acc_be[i]) begin
            wr_word[8*i +: 8] = acc_wdata[8*i +: 8];
         end
      end
   end

   // A reset on the access edge discards the pending store.
   assign mem_wr = acc_go && acc_we && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_wr) begin
         mem[acc_idx] <= wr_word;
      end
   end

   assign ack   = ack_q;
   assign err   = err_q;
   assign rdata = rdata_q;
   assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Directed bench for mips_dmem_responder. Instance 0 has LATENCY=2, instance 1 LATENCY=0,
// instance 2 LATENCY=3; all use ADDR_W=10.
module tb_mips_dmem_responder;

   logic        clk = 1'b0;
   logic        rst   [3];
   logic        req   [3];
   logic        we    [3];
   logic [31:0] addr  [3];
   logic [31:0] wdata [3];
   logic [3:0]  be    [3];
   logic        ack   [3];
   logic [31:0] rdata [3];
   logic        err   [3];
   logic        busy  [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mips_dmem_responder #(.ADDR_W(10), .LATENCY(2)) u_l2 (
      .clk(clk), .reset(rst[0]), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
      .be(be[0]), .ack(ack[0]), .rdata(rdata[0]), .err(err[0]), .busy(busy[0])
   );
   mips_dmem_responder #(.ADDR_W(10), .LATENCY(0)) u_l0 (
      .clk(clk), .reset(rst[1]), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
      .be(be[1]), .ack(ack[1]), .rdata(rdata[1]), .err(err[1]), .busy(busy[1])
   );
   mips_dmem_responder #(.ADDR_W(10), .LATENCY(3)) u_l3 (
      .clk(clk), .reset(rst[2]), .req(req[2]), .we(we[2]), .addr(addr[2]), .wdata(wdata[2]),
      .be(be[2]), .ack(ack[2]), .rdata(rdata[2]), .err(err[2]), .busy(busy[2])
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One request on instance s; cycle 0 is the accept cycle. Inputs are scrambled after the
   // accept edge so only latched values can produce the right result.
   task automatic xfer(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, output int ack_cyc, output logic err_o,
                       output logic [31:0] rd_o, output logic [7:0] bmask);
      req[s] = 1'b1; we[s] = w; addr[s] = a; wdata[s] = d; be[s] = b;
      ack_cyc = -1; err_o = 1'b0; rd_o = '0; bmask = '0;
      for (int c = 1; c <= 20 && ack_cyc < 0; c++) begin
         tick();
         if (c == 1) begin
            req[s] = 1'b0; we[s] = ~w; addr[s] = 32'hFFFF_FFFF; wdata[s] = ~d; be[s] = ~b;
         end
         if (c < 8) bmask[c] = busy[s];
         if (ack[s]) begin
            ack_cyc = c; err_o = err[s]; rd_o = rdata[s];
         end
      end
      tick();
   endtask

   int          ac;
   logic        e;
   logic [31:0] rd;
   logic [7:0]  bm;
   int          stray;

   initial begin
      for (int i = 0; i < 3; i++) begin
         rst[i] = 1'b1; req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0; be[i] = '0;
      end
      tick();
      tick();
      for (int i = 0; i < 3; i += 2) begin
         chk($sformatf("rst_ack%0d", i), 32'(ack[i]), 32'd0);
         chk($sformatf("rst_err%0d", i), 32'(err[i]), 32'd0);
         chk($sformatf("rst_busy%0d", i), 32'(busy[i]), 32'd0);
         chk($sformatf("rst_rdata%0d", i), rdata[i], 32'd0);
      end
      for (int i = 0; i < 3; i++) rst[i] = 1'b0;
      tick();

      // LATENCY=2: store then load
      xfer(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, ac, e, rd, bm);
      chk("st_ack_cyc", 32'(ac), 32'd3);
      chk("st_err", 32'(e), 32'd0);
      xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, ac, e, rd, bm);
      chk("ld_ack_cyc", 32'(ac), 32'd3);
      chk("ld_rdata", rd, 32'hDEAD_BEEF);
      chk("ld_busy_mask", 32'(bm), 32'h0E);

      // Byte lanes
      xfer(0, 1'b1, 32'h10, 32'h1122_3344, 4'b0101, ac, e, rd, bm);
      chk("be5_ack_cyc", 32'(ac), 32'd3);
      xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, ac, e, rd, bm);
      chk("be5_rdata", rd, 32'hDE22_BE44);
      xfer(0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, ac, e, rd, bm);
      chk("be0_ack_cyc", 32'(ac), 32'd3);
      xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, ac, e, rd, bm);
      chk("be0_rdata", rd, 32'hDE22_BE44);

      // Address errors
      xfer(0, 1'b0, 32'h13, 32'h0, 4'h0, ac, e, rd, bm);
      chk("mis_ack_cyc", 32'(ac), 32'd1);
      chk("mis_err", 32'(e), 32'd1);
      chk("mis_rdata", rd, 32'd0);
      chk("mis_busy_mask", 32'(bm), 32'h02);
      xfer(0, 1'b0, 32'h1000, 32'h0, 4'h0, ac, e, rd, bm);
      chk("oob_ack_cyc", 32'(ac), 32'd1);
      chk("oob_err", 32'(e), 32'd1);
      chk("oob_rdata", rd, 32'd0);
      xfer(0, 1'b1, 32'h1010, 32'h5555_5555, 4'hF, ac, e, rd, bm);
      chk("oob_st_err", 32'(e), 32'd1);
      xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, ac, e, rd, bm);
      chk("after_err_rdata", rd, 32'hDE22_BE44);
      chk("after_err_err", 32'(e), 32'd0);

      // Request changed while busy
      xfer(0, 1'b1, 32'h24, 32'h0, 4'hF, ac, e, rd, bm);
      req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'hAAAA_5555; be[0] = 4'hF;
      tick();
      addr[0] = 32'h24; wdata[0] = 32'h9999_9999;
      chk("rwb_c1_busy", 32'(busy[0]), 32'd1);
      chk("rwb_c1_ack", 32'(ack[0]), 32'd0);
      tick();
      chk("rwb_c2_ack", 32'(ack[0]), 32'd0);
      tick();
      chk("rwb_c3_ack", 32'(ack[0]), 32'd1);
      tick();
      chk("rwb_c4_busy", 32'(busy[0]), 32'd0);
      chk("rwb_c4_ack", 32'(ack[0]), 32'd0);
      tick();
      req[0] = 1'b0;
      chk("rwb_c5_busy", 32'(busy[0]), 32'd1);
      tick();
      tick();
      chk("rwb_c7_ack", 32'(ack[0]), 32'd1);
      tick();
      xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, ac, e, rd, bm);
      chk("rwb_word20", rd, 32'hAAAA_5555);
      xfer(0, 1'b0, 32'h24, 32'h0, 4'h0, ac, e, rd, bm);
      chk("rwb_word24", rd, 32'h9999_9999);

      // LATENCY=0 with req held high across store then load
      req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h4; wdata[1] = 32'h0000_CAFE; be[1] = 4'hF;
      tick();
      chk("l0_c1_ack", 32'(ack[1]), 32'd1);
      chk("l0_c1_err", 32'(err[1]), 32'd0);
      we[1] = 1'b0; wdata[1] = 32'h0; be[1] = 4'h0;
      tick();
      chk("l0_c2_ack", 32'(ack[1]), 32'd0);
      chk("l0_c2_busy", 32'(busy[1]), 32'd0);
      tick();
      chk("l0_c3_ack", 32'(ack[1]), 32'd1);
      chk("l0_c3_rdata", rdata[1], 32'h0000_CAFE);
      req[1] = 1'b0;
      tick();

      // LATENCY=3: reset during WAIT discards the store
      xfer(2, 1'b1, 32'h8, 32'h0, 4'hF, ac, e, rd, bm);
      chk("l3_init_ack_cyc", 32'(ac), 32'd4);
      req[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h8; wdata[2] = 32'h1234_5678; be[2] = 4'hF;
      tick();
      req[2] = 1'b0;
      chk("rst_mid_c1_busy", 32'(busy[2]), 32'd1);
      tick();
      rst[2] = 1'b1;
      tick();
      chk("rst_mid_ack", 32'(ack[2]), 32'd0);
      chk("rst_mid_busy", 32'(busy[2]), 32'd0);
      rst[2] = 1'b0;
      stray = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (ack[2]) stray++;
      end
      chk("rst_mid_no_ack", 32'(stray), 32'd0);
      xfer(2, 1'b0, 32'h8, 32'h0, 4'h0, ac, e, rd, bm);
      chk("rst_mid_ld_cyc", 32'(ac), 32'd4);
      chk("rst_mid_ld_rdata", rd, 32'h0000_0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mips_dmem_responder.md
Name: mips_dmem_responder

Overview:
- Responder (slave) end of the CPU data-memory interface: the module that answers load/store requests issued by the datapath.
- Word-organised RAM behind a req/ack handshake, with programmable wait states, byte-lane write enables and an address-error response.
- Replaces the zero-latency data memory so the CPU and a multi-cycle controller can be verified against realistic memory timing.

Parameters:
- ADDR_W, 10, word-index bits; depth = 2^ADDR_W words of 32 bits.
- LATENCY, 2, wait-state cycles before the access, legal range 0..15.

Ports:
- clk  input  1  system clock; everything updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  1  request valid; sampled only in IDLE.
- we  input  1  1 = store, 0 = load.
- addr  input  32  byte address.
- wdata  input  32  store data.
- be  input  4  byte enables for stores; be[i] selects wdata[8i+7:8i].
- ack  output  1  one-cycle completion pulse.
- rdata  output  32  load data; valid while ack=1 and held afterwards.
- err  output  1  error flag; qualifies ack.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: state=IDLE, ack=0, err=0, rdata=0, busy=0, wait counter=0. RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE with req=1 on an edge (accept):
  - Latch we, addr, wdata and be.
  - Address is illegal if addr[1:0]!=0 or any bit of addr[31:ADDR_W+2] is 1. Illegal: go to RESP with the error flag set; no RAM access.
  - Legal and LATENCY=0: perform the access on this edge, then go to RESP.
  - Legal and LATENCY>0: load counter with LATENCY, go to WAIT.
- IDLE with req=0: stay in IDLE.
- WAIT: counter decrements each edge. On the edge where counter==1, perform the access and go to RESP. WAIT therefore lasts exactly LATENCY cycles.
- Access, load: rdata <= mem[addr[ADDR_W+1:2]] as a full word; be is ignored.
- Access, store: for each i with be[i]=1, update byte i of the word. be=4'b0000 leaves the word unchanged but still completes with ack. rdata is unchanged by stores.
- RESP: ack=1 for exactly this cycle. err=1 only for an illegal address. On an error response rdata <= 0. Next state is IDLE.
- Latency:
  - Legal request: ack is high in cycle LATENCY+1, counting the accept cycle as cycle 0.
  - Illegal request: ack is high in cycle 1 regardless of LATENCY.
- Handshake:
  - req, we, addr, wdata and be are ignored outside IDLE; the latched copies are used.
  - The requester may drop req after the accept edge.
  - If req is high in the IDLE cycle following RESP, it is a new request. Back-to-back requests are spaced LATENCY+2 cycles apart.
- busy is combinational from state: busy = (state != IDLE).
- Reset mid-operation: returns to IDLE at once, no ack is issued, and a store not yet performed (still in WAIT) is discarded.
- Read-after-write to the same word: a load accepted after a store's ack returns the new data.

Test Plan:
- LATENCY=2, after reset:
  - Store addr=0x00000010, wdata=0xDEADBEEF, be=4'hF: ack in cycle 3, err=0.
  - Then load addr=0x10: ack in cycle 3 with rdata=0xDEADBEEF, busy high in cycles 1-3.
- Byte lanes: starting from word 0x10 = 0xDEADBEEF:
  - Store wdata=0x11223344, be=4'b0101, then load: rdata=0xDE22BE44.
  - Store with be=0 leaves the word at 0xDE22BE44; ack still pulses.
- Errors, LATENCY=2:
  - Load addr=0x00000013: ack and err both high in cycle 1, rdata=0.
  - Load addr=0x00001000 (ADDR_W=10): same error response.
  - No RAM word changes in either case.
- LATENCY=0:
  - Store addr=0x4, wdata=0x0000CAFE, be=4'hF, with req held high continuously and changed to a load of 0x4 after the store's ack.
  - Required: acks in cycles 1 and 3; the second returns rdata=0x0000CAFE.
- Reset mid-WAIT, LATENCY=3:
  - Store 0x12345678 to addr=0x8 (word previously 0x0). Assert reset in cycle 2.
  - Required: no ack, busy=0 after the reset edge, and a subsequent load of 0x8 returns 0x00000000.
- Request while busy, LATENCY=2:
  - Change addr/wdata mid-WAIT.
  - Required: the access uses the latched values; the new values are not accepted until IDLE.
